// File: rtl/mr_datapath.sv
// mr_datapath: operand/result store and arithmetic datapath driven by an
// external loop controller. Operands a/b are streamed in during LOAD, the
// controller sequences loads, multiplies, adds and result stores in RUN,
// and results in c are read back through a registered port in DONE.
//
// state | meaning
// LOAD  | accepting operand words into a then b (write pointer wp)
// RUN   | executing controller command strobes
// DONE  | read-back of c; held until rst
module mr_datapath #(
  parameter int DEPTH = 1024,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                n,
  input  logic                       we,
  input  logic [W-1:0]               wdata,
  input  logic                       store_ab,
  input  logic                       load_a_en,
  input  logic                       load_b_en,
  input  logic                       load_c_en,
  input  logic                       store_c_en,
  input  logic                       mul_en,
  input  logic                       add_en,
  input  logic [1:0]                 mul_sel,
  input  logic [1:0]                 add_sel,
  input  logic [$clog2(DEPTH)-1:0]   index_loop,
  input  logic                       done,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [W-1:0]               rd_data,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       wr_ovf
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, DONE = 2'd2} phase_t;

  phase_t phase;

  // wp counts up to 2n, so it needs one bit more than n
  logic [32:0]   wp;
  logic [32:0]   n_ext;
  logic [32:0]   n2;
  logic [IW-1:0] b_idx;

  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_b [DEPTH];
  logic [W-1:0] mem_c [DEPTH];

  logic [W-1:0] ra, rb, rc, rm, rs;
  logic         last_mul;

  logic         in_load, in_run, wr_fire, a_wr, b_wr, ovf_hit;
  logic         idx_ok, rd_ok, mul_upd, add_upd, c_wr;
  logic [W-1:0] mul_res, c_src;

  // Command qualification and next-value selection
  always_comb begin
    n_ext   = {1'b0, n};
    n2      = {n, 1'b0};
    b_idx   = wp[IW-1:0] - n[IW-1:0];
    in_load = (phase == LOAD);
    in_run  = (phase == RUN);
    wr_fire = !rst && in_load && store_ab && we;
    a_wr    = wr_fire && (wp < n_ext);
    b_wr    = wr_fire && (wp >= n_ext) && (wp < n2);
    ovf_hit = wr_fire && (wp >= n2);
    idx_ok  = {{(32-IW){1'b0}}, index_loop} < n;
    rd_ok   = {{(32-IW){1'b0}}, rd_addr} < n;
    mul_upd = in_run && mul_en && (mul_sel != 2'b00);
    add_upd = in_run && add_en && (add_sel == 2'b01 || add_sel == 2'b10);
    c_wr    = !rst && in_run && store_c_en && idx_ok;
    c_src   = last_mul ? rm : rs;
    case (mul_sel)
      2'b01:   mul_res = rb * W'(2);
      2'b10:   mul_res = rb * W'(5);
      2'b11:   mul_res = rc * rs;
      default: mul_res = '0;
    endcase
  end

  // Phase sequencing, operand write pointer and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= LOAD;
      wp     <= '0;
      wr_ovf <= 1'b0;
    end else begin
      case (phase)
        LOAD: begin
          if (ovf_hit) wr_ovf <= 1'b1;
          else if (wr_fire) wp <= wp + 33'd1;
          if (!store_ab && wp != '0) phase <= RUN;
        end
        RUN: if (done) phase <= DONE;
        default: ;
      endcase
    end
  end

  // Working registers; all commands see pre-edge values
  always_ff @(posedge clk) begin
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      rc       <= '0;
      rm       <= '0;
      rs       <= '0;
      last_mul <= 1'b0;
    end else begin
      if (in_run && idx_ok) begin
        if (load_a_en) ra <= mem_a[index_loop];
        if (load_b_en) rb <= mem_b[index_loop];
        if (load_c_en) rc <= mem_c[index_loop];
      end
      if (mul_upd) rm <= mul_res;
      if (add_upd) rs <= ra + rm;
      // multiply wins the source flag when both update together
      if (mul_upd) last_mul <= 1'b1;
      else if (add_upd) last_mul <= 1'b0;
    end
  end

  // Array writes; contents survive reset
  always_ff @(posedge clk) begin
    if (a_wr) mem_a[wp[IW-1:0]] <= wdata;
    if (b_wr) mem_b[b_idx] <= wdata;
    if (c_wr) mem_c[index_loop] <= c_src;
  end

  // Registered result read-back, only live in DONE
  always_ff @(posedge clk) begin
    if (rst || phase != DONE) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= rd_ok ? mem_c[rd_addr] : '0;
      rd_valid <= 1'b1;
    end
  end

  assign busy = (phase != DONE);

endmodule

// File: tb/tb_mr_datapath.sv
// Testbench for mr_datapath: directed scenarios with known results plus
// randomized command streams checked against a behavioural model.
module tb_mr_datapath;

  logic        clk;
  logic        rst;
  logic [31:0] n;
  logic        we;
  logic [31:0] wdata;
  logic        store_ab, load_a_en, load_b_en, load_c_en, store_c_en, mul_en, add_en;
  logic [1:0]  mul_sel, add_sel;
  logic [9:0]  index_loop;
  logic        done;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid, busy, wr_ovf;

  int checks;
  int errors;

  // reference model state
  logic [31:0] ma [0:1023];
  logic [31:0] mb [0:1023];
  logic [31:0] mc [0:1023];
  int          mph;        // 0 load, 1 run, 2 done
  logic [32:0] mwp;
  logic        movf;
  logic        mlast;      // 1 = last result came from multiply
  logic [31:0] mra, mrb, mrc, mrm, mrs, mrd;
  logic        mrv;

  mr_datapath #(.DEPTH(1024), .W(32)) dut (
    .clk(clk), .rst(rst), .n(n), .we(we), .wdata(wdata),
    .store_ab(store_ab), .load_a_en(load_a_en), .load_b_en(load_b_en),
    .load_c_en(load_c_en), .store_c_en(store_c_en), .mul_en(mul_en),
    .add_en(add_en), .mul_sel(mul_sel), .add_sel(add_sel),
    .index_loop(index_loop), .done(done), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .wr_ovf(wr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    we = 0; wdata = 0; store_ab = 0; load_a_en = 0; load_b_en = 0; load_c_en = 0;
    store_c_en = 0; mul_en = 0; add_en = 0; mul_sel = 0; add_sel = 0;
    index_loop = 0; done = 0;
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT,
  // then compare every output.
  task automatic cycle();
    logic [31:0] ora, orb, orc, orm, ors;
    logic        olast, mupd;
    int          oph;
    ora = mra; orb = mrb; orc = mrc; orm = mrm; ors = mrs; olast = mlast; oph = mph;
    mupd = 0;
    if (rst) begin
      mph = 0; mwp = 0; movf = 0; mlast = 0;
      mra = 0; mrb = 0; mrc = 0; mrm = 0; mrs = 0; mrd = 0; mrv = 0;
    end else begin
      mrv = (oph == 2);
      mrd = (oph == 2 && rd_addr < n) ? mc[rd_addr] : 32'h0;
      if (oph == 0) begin
        if (store_ab && we) begin
          if (mwp < n) ma[mwp] = wdata;
          else if (mwp < 2 * n) mb[mwp - n] = wdata;
          else movf = 1;
          if (mwp < 2 * n) mwp = mwp + 1;
        end
        if (!store_ab && mwp > 0) mph = 1;
      end else if (oph == 1) begin
        if (index_loop < n) begin
          if (load_a_en) mra = ma[index_loop];
          if (load_b_en) mrb = mb[index_loop];
          if (load_c_en) mrc = mc[index_loop];
          if (store_c_en) mc[index_loop] = olast ? orm : ors;
        end
        if (mul_en && mul_sel != 0) begin
          mupd = 1;
          mlast = 1;
          if (mul_sel == 1) mrm = orb * 2;
          else if (mul_sel == 2) mrm = orb * 5;
          else mrm = orc * ors;
        end
        if (add_en && (add_sel == 1 || add_sel == 2)) begin
          mrs = ora + orm;
          if (!mupd) mlast = 0;
        end
        if (done) mph = 2;
      end
    end
    @(posedge clk); #1;
    chk("busy", {31'b0, busy}, {31'b0, mph != 2});
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, mrv});
    chk("rd_data", rd_data, mrd);
    chk("wr_ovf", {31'b0, wr_ovf}, {31'b0, movf});
  endtask

  task automatic do_reset(input int nn);
    clr(); rst = 1; n = nn; rd_addr = 0;
    cycle();
    rst = 0;
  endtask

  task automatic wr(input logic [31:0] w);
    clr(); store_ab = 1; we = 1; wdata = w;
    cycle();
  endtask

  task automatic go_run();
    clr(); cycle();
  endtask

  task automatic finish_run();
    clr(); done = 1; cycle();
    clr(); cycle();
  endtask

  task automatic step(input logic la, lb, lc, sc, input logic [1:0] ms, as, input int i);
    clr();
    load_a_en = la; load_b_en = lb; load_c_en = lc; store_c_en = sc;
    mul_en = (ms != 0); mul_sel = ms; add_en = (as != 0); add_sel = as;
    index_loop = 10'(i);
    cycle();
  endtask

  task automatic loop1(input int i);
    step(0, 1, 0, 0, 2'd0, 2'd0, i);
    step(1, 0, 0, 0, 2'd1, 2'd0, i);
    step(0, 0, 0, 0, 2'd0, 2'd1, i);
    step(0, 0, 0, 1, 2'd0, 2'd0, i);
  endtask

  task automatic loop2(input int i);
    step(0, 1, 0, 0, 2'd0, 2'd0, i);
    step(1, 0, 0, 0, 2'd2, 2'd0, i);
    step(0, 0, 1, 0, 2'd0, 2'd2, i);
    step(0, 0, 0, 0, 2'd3, 2'd0, i);
    step(0, 0, 0, 1, 2'd0, 2'd0, i);
  endtask

  task automatic rdchk(input string tag, input int addr, input logic [31:0] exp);
    clr(); rd_addr = 10'(addr);
    cycle();
    chk(tag, rd_data, exp);
    chk({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    rst = 1; n = 2; rd_addr = 0;

    // reset state
    do_reset(2);
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_wr_ovf", {31'b0, wr_ovf}, 32'd0);

    // loop 1 with an overflowing fifth write
    wr(3); wr(4); wr(1); wr(2);
    chk("ovf_after_4", {31'b0, wr_ovf}, 32'd0);
    wr(32'h99);
    chk("ovf_after_5", {31'b0, wr_ovf}, 32'd1);
    go_run();
    loop1(0); loop1(1);
    finish_run();
    chk("done_busy", {31'b0, busy}, 32'd0);
    rdchk("loop1_c0", 0, 32'd5);
    rdchk("loop1_c1", 1, 32'd8);
    rdchk("addr_ge_n", 2, 32'd0);

    // loops 1 and 2
    do_reset(2);
    wr(3); wr(4); wr(1); wr(2);
    go_run();
    loop1(0); loop1(1); loop2(0); loop2(1);
    finish_run();
    rdchk("loop2_c0", 0, 32'd40);
    rdchk("loop2_c1", 1, 32'd112);

    // wrap-around
    do_reset(1);
    wr(32'hFFFF_FFFF); wr(1);
    go_run(); loop1(0); finish_run();
    rdchk("wrap_loop1", 0, 32'd1);
    do_reset(1);
    wr(32'hFFFF_FFFF); wr(1);
    go_run(); loop1(0); loop2(0); finish_run();
    rdchk("wrap_loop2", 0, 32'd4);

    // null mul/add selects leave result and source flag alone
    do_reset(1);
    wr(3); wr(1);
    go_run();
    step(0, 1, 0, 0, 2'd0, 2'd0, 0);
    step(1, 0, 0, 0, 2'd1, 2'd0, 0);
    step(0, 0, 0, 0, 2'd0, 2'd1, 0);
    step(0, 0, 0, 0, 2'd1, 2'd0, 0);
    clr(); add_en = 1; add_sel = 2'd3; cycle();
    clr(); mul_en = 1; mul_sel = 2'd0; cycle();
    step(0, 0, 0, 1, 2'd0, 2'd0, 0);
    finish_run();
    rdchk("null_ops", 0, 32'd2);

    // reset in the middle of RUN
    do_reset(2);
    wr(3); wr(4); wr(1); wr(2); wr(7);
    go_run();
    step(0, 1, 0, 0, 2'd0, 2'd0, 0);
    step(1, 0, 0, 0, 2'd1, 2'd0, 0);
    step(0, 0, 0, 0, 2'd0, 2'd1, 0);
    clr(); rst = 1; cycle(); rst = 0;
    chk("midrst_busy", {31'b0, busy}, 32'd1);
    chk("midrst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("midrst_wr_ovf", {31'b0, wr_ovf}, 32'd0);
    wr(3); wr(4); wr(1); wr(2);
    go_run();
    step(0, 0, 0, 1, 2'd0, 2'd0, 0);
    step(0, 0, 0, 0, 2'd1, 2'd1, 0);
    step(0, 0, 0, 1, 2'd0, 2'd0, 1);
    finish_run();
    rdchk("midrst_rs", 0, 32'd0);
    rdchk("midrst_rm", 1, 32'd0);

    // randomized passes against the model
    for (int pass = 0; pass < 4; pass++) begin
      int nn;
      nn = int'($urandom_range(1, 6));
      do_reset(nn);
      repeat (2 * nn + int'($urandom_range(0, 2))) wr($urandom);
      go_run();
      for (int i = 0; i < nn; i++) loop1(i);
      for (int i = 0; i < nn; i++) loop2(i);
      repeat (40) begin
        clr();
        load_a_en = 1'($urandom); load_b_en = 1'($urandom); load_c_en = 1'($urandom);
        store_c_en = 1'($urandom); mul_en = 1'($urandom); add_en = 1'($urandom);
        mul_sel = 2'($urandom); add_sel = 2'($urandom);
        we = 1'($urandom); store_ab = 1'($urandom); wdata = $urandom;
        index_loop = 10'($urandom_range(0, nn + 1));
        cycle();
      end
      finish_run();
      for (int a = 0; a < nn + 2; a++) begin
        clr(); rd_addr = 10'(a); cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mr_datapath.md
MR_DATAPATH -- requirements
Module: mr_datapath

Interface
REQ-001 Parameter: DEPTH, 1024, entries per array (a, b, c); index_loop range 0..DEPTH-1.
REQ-002 Parameter: W, 32, data word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 n  input  32  element count; held stable from reset release to done.
REQ-006 we  input  1  operand write strobe.
REQ-007 wdata  input  W  operand write data.
REQ-008 store_ab, load_a_en, load_b_en, load_c_en, store_c_en, mul_en, add_en  input  1 each  command strobes from the loop controller.
REQ-009 mul_sel, add_sel  input  2 each  operation selects.
REQ-010 index_loop  input  10  element index for loads and stores.
REQ-011 done  input  1  controller completion flag.
REQ-012 rd_addr  input  10  result read address.
REQ-013 rd_data  output  W  registered result read data.
REQ-014 rd_valid  output  1  rd_data valid; high 1 cycle after each DONE-phase read.
REQ-015 busy  output  1  high in LOAD and RUN phases.
REQ-016 wr_ovf  output  1  sticky: operand write attempted beyond 2n words.

Function
REQ-017 Phase FSM states LOAD, RUN, DONE; LOAD after reset; LOAD->RUN on first cycle with store_ab=0 and write count wp>0; RUN->DONE when done=1; DONE held until rst.
REQ-018 LOAD: each cycle with store_ab=1 and we=1: wp<n -> a[wp]<=wdata; n<=wp<2n -> b[wp-n]<=wdata; wp>=2n -> no write, wr_ovf<=1; wp increments, saturating at 2n.
REQ-019 we or store_ab in RUN/DONE ignored; no array write, wp unchanged.
REQ-020 RUN, load_a_en: ra<=a[index_loop]; load_b_en: rb<=b[index_loop]; load_c_en: rc<=c[index_loop].
REQ-021 RUN, mul_en: mul_sel 01 -> rm<=rb*2; 10 -> rm<=rb*5; 11 -> rm<=rc*rs; 00 -> no update.
REQ-022 RUN, add_en: add_sel 01 or 10 -> rs<=ra+rm; 00 or 11 -> no update.
REQ-023 Arithmetic modulo 2^W; products truncated to low W bits; no saturation or overflow flag.
REQ-024 All commands in one cycle use pre-edge register values (e.g. add_en with load_a_en adds old ra); any combination may be simultaneous.
REQ-025 last_src flag: set to MUL on an updating mul_en, ADD on an updating add_en; if both update in one cycle, MUL.
REQ-026 RUN, store_c_en: c[index_loop]<=(last_src==MUL ? rm : rs), written at the edge where the strobe is sampled high.
REQ-027 Any load or store with index_loop>=n: no register or array update.
REQ-028 Commands outside RUN ignored.
REQ-029 DONE: rd_data<=c[rd_addr] each cycle, rd_valid<=1; rd_addr>=n returns 0; outside DONE rd_data<=0, rd_valid<=0.
REQ-030 busy=1 in LOAD and RUN, 0 in DONE.

Reset
REQ-031 rst=1 at a clock edge: phase<=LOAD, wp<=0, ra/rb/rc/rm/rs<=0, last_src<=ADD, rd_data<=0, rd_valid<=0, wr_ovf<=0, busy<=1.
REQ-032 Array contents not cleared by reset; mid-RUN reset abandons the pass; c entries must be rewritten before reuse.

Verification
REQ-033 n=2, writes 3,4,1,2; loop-1 commands (load_b, load_a+mul 01, add 01, store_c) per index -> c={5,8}.
REQ-034 Continue with loop-2 commands (load_b, load_a+mul 10, load_c+add 10, mul 11, store_c) per index, then done -> rd_addr 0/1 returns 40/112, rd_valid 1 cycle after each address.
REQ-035 n=1, a=0xFFFFFFFF, b=1; loops 1 and 2 -> c[0]=1 after loop 1, 4 after loop 2 (wrap).
REQ-036 n=2, five we pulses in LOAD -> wr_ovf=1 after the fifth, arrays hold first four words.
REQ-037 mul_en with mul_sel=00, add_en with add_sel=11 -> rm, rs, last_src unchanged; following store_c writes the prior result.
REQ-038 rst asserted mid-RUN -> next cycle phase LOAD, busy=1, rd_valid=0, wr_ovf=0, ra/rb/rc/rm/rs=0.
